// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   EX-stage branch resolution plus a direct-mapped BTB with 2-bit
//   saturating counters that drives fetch-stage prediction. It also
//   detects mispredictions and supplies the fetch redirect PC.
//
// Optional build macro: BRANCH_PERF_EN adds saturating branch and
//   mispredict counters. When it is not defined, both count outputs are
//   tied to 0 and no counter flops exist.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   fetch_pc          PC being fetched; the lookup is combinational
//   pred_taken/target fetch prediction (target is 0 when not taken)
//   ex_*              EX-stage instruction and the prediction it carried
//   branchTarget, op1 immediate target and return-address operand
//   isRet..isBgt      decoded branch type
//   flagsE, flagsGT   flags register
//   branchPC, isBranchTaken   resolved branch (always combinational)
//   mispredict, redirect_pc   flush request and fetch restart PC
//   branch_count, mispredict_count   perf counters (feature only)
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic [31:0]      branchTarget,
  input  logic [31:0]      op1,
  input  logic             isRet,
  input  logic             isUBranch,
  input  logic             isBeq,
  input  logic             isBgt,
  input  logic             flagsE,
  input  logic             flagsGT,
  output logic [31:0]      branchPC,
  output logic             isBranchTaken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // BTB storage; tag and target are never reset, only valid and ctr are.
  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][TAG_W-1:0] tag;
  logic [ENTRIES-1:0][31:0]      target;
  logic [ENTRIES-1:0][1:0]       ctr;

  // Word-aligned PCs: the low two bits take no part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

  // Fetch lookup. The BTB is read before the write, so an update in this
  // cycle becomes visible on the next cycle.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  assign f_idx       = fetch_pc[IDX_W+1:2];
  assign f_tag       = fetch_pc[31:IDX_W+2];
  assign f_hit       = valid[f_idx] && (tag[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr[f_idx][1];
  assign pred_target = pred_taken ? target[f_idx] : 32'd0;

  // EX-side lookup used by the update rules.
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[31:IDX_W+2];
  assign e_hit = valid[e_idx] && (tag[e_idx] == e_tag);

  // Resolution. Returns reach "taken" only through isUBranch; isRet only
  // chooses op1 as the target.
  logic is_br;
  assign is_br         = isRet | isUBranch | isBeq | isBgt;
  assign branchPC      = isRet ? op1 : branchTarget;
  assign isBranchTaken = isUBranch | (isBeq & flagsE) | (isBgt & flagsGT);
  assign mispredict    = ex_valid &
                         ((ex_pred_taken != isBranchTaken) |
                          (isBranchTaken & (ex_pred_target != branchPC)));
  assign redirect_pc   = isBranchTaken ? branchPC : ex_pc + 32'd4;

  logic [1:0] e_ctr;
  assign e_ctr = ctr[e_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (ex_valid) begin
      if (is_br) begin
        if (e_hit) begin
          if (isBranchTaken) begin
            ctr[e_idx]    <= (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'd1;
            target[e_idx] <= branchPC;
          end else begin
            ctr[e_idx]    <= (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'd1;
          end
        end else if (isBranchTaken) begin
          // A taken miss allocates the entry and replaces whatever occupies the slot.
          valid[e_idx]  <= 1'b1;
          tag[e_idx]    <= e_tag;
          target[e_idx] <= branchPC;
          ctr[e_idx]    <= 2'b10;
        end
      end else if (e_hit) begin
        // A non-branch that hits is an alias, so the entry is dropped.
        valid[e_idx] <= 1'b0;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (ex_valid && is_br && (br_cnt != '1)) br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict && (mp_cnt != '1))        mp_cnt <= mp_cnt + CNT_W'(1);
    end
  end

  assign branch_count     = br_cnt;
  assign mispredict_count = mp_cnt;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int ENTRIES = 16;
  localparam int LG      = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      fetch_pc = '0;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid = 1'b0;
  logic [31:0]      ex_pc = '0;
  logic             ex_pred_taken = 1'b0;
  logic [31:0]      ex_pred_target = '0;
  logic [31:0]      branchTarget = '0;
  logic [31:0]      op1 = '0;
  logic             isRet = 1'b0, isUBranch = 1'b0, isBeq = 1'b0, isBgt = 1'b0;
  logic             flagsE = 1'b0, flagsGT = 1'b0;
  logic [31:0]      branchPC;
  logic             isBranchTaken;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predict_unit #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .branchTarget(branchTarget), .op1(op1),
    .isRet(isRet), .isUBranch(isUBranch), .isBeq(isBeq), .isBgt(isBgt),
    .flagsE(flagsE), .flagsGT(flagsGT), .branchPC(branchPC),
    .isBranchTaken(isBranchTaken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_bcnt, m_mcnt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (2 + LG);
  endfunction
  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction
  function automatic bit m_ptk(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction
  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_ptk(pc) ? m_tgt[m_idx(pc)] : 32'd0;
  endfunction

  function automatic logic [31:0] e_bpc();
    return isRet ? op1 : branchTarget;
  endfunction
  function automatic bit e_tk();
    return isUBranch || (isBeq && flagsE) || (isBgt && flagsGT);
  endfunction
  function automatic bit e_mis();
    return ex_valid && ((ex_pred_taken != e_tk()) || (e_tk() && (ex_pred_target != e_bpc())));
  endfunction
  function automatic logic [31:0] e_redir();
    return e_tk() ? e_bpc() : ex_pc + 32'd4;
  endfunction

  task automatic model_update();
    int i;
    bit br, h, tk;
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
      m_bcnt = 0; m_mcnt = 0;
      return;
    end
    br = isRet || isUBranch || isBeq || isBgt;
    i  = m_idx(ex_pc);
    h  = m_hit(ex_pc);
    tk = e_tk();
    if (ex_valid && br && m_bcnt < (1 << CNT_W) - 1) m_bcnt++;
    if (e_mis() && m_mcnt < (1 << CNT_W) - 1) m_mcnt++;
    if (!ex_valid) return;
    if (br) begin
      if (h && tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = e_bpc();
      end else if (h) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = m_tagof(ex_pc); m_tgt[i] = e_bpc(); m_ctr[i] = 2;
      end
    end else if (h) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // typ = {isRet, isUBranch, isBeq, isBgt}
  task automatic ex_set(input logic v, input logic [31:0] pc, input logic [3:0] typ,
                        input logic e, input logic gt, input logic [31:0] bt,
                        input logic [31:0] o1, input logic ept, input logic [31:0] eptt);
    ex_valid = v; ex_pc = pc;
    {isRet, isUBranch, isBeq, isBgt} = typ;
    flagsE = e; flagsGT = gt; branchTarget = bt; op1 = o1;
    ex_pred_taken = ept; ex_pred_target = eptt;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [3:0]  typ;
    logic        e, gt;
    logic [31:0] bt, o1;
    logic        ept;
    logic [31:0] eptt;
    logic [31:0] x_bpc;
    logic        x_tk, x_mis;
    logic [31:0] x_redir;
  } vec_t;

  vec_t vt [10];

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    //         v  pc            typ     e  gt bt            o1            ept eptt          bpc           tk mis redir
    vt[0] = '{1, 32'h40,       4'b0010, 1, 0, 32'h100,     32'h0,        0, 32'h0,       32'h100,      1, 1, 32'h100};
    vt[1] = '{1, 32'h40,       4'b0010, 0, 1, 32'h100,     32'h0,        0, 32'h0,       32'h100,      0, 0, 32'h44};
    vt[2] = '{1, 32'h80,       4'b0001, 0, 1, 32'h800,     32'h0,        1, 32'h800,     32'h800,      1, 0, 32'h800};
    vt[3] = '{1, 32'h80,       4'b0001, 0, 1, 32'h800,     32'h0,        1, 32'h804,     32'h800,      1, 1, 32'h800};
    vt[4] = '{1, 32'h40,       4'b1100, 0, 0, 32'h300,     32'h2000,     1, 32'h300,     32'h2000,     1, 1, 32'h2000};
    vt[5] = '{1, 32'h50,       4'b1000, 0, 0, 32'h300,     32'h1234,     0, 32'h0,       32'h1234,     0, 0, 32'h54};
    vt[6] = '{1, 32'hFFFFFFFC, 4'b0000, 1, 1, 32'h300,     32'h0,        1, 32'h300,     32'h300,      0, 1, 32'h0};
    vt[7] = '{0, 32'h80,       4'b0001, 0, 1, 32'h800,     32'h0,        1, 32'h804,     32'h800,      1, 0, 32'h800};
    vt[8] = '{1, 32'h90,       4'b0001, 1, 0, 32'h700,     32'h0,        0, 32'h0,       32'h700,      0, 0, 32'h94};
    vt[9] = '{1, 32'hA0,       4'b0100, 0, 0, 32'hABC0,    32'h0,        1, 32'hABC0,    32'hABC0,     1, 0, 32'hABC0};

    // reset
    tick(); tick();
    chk("reset_pred_taken", 32'(pred_taken), 32'd0);

    // resolution table, held in reset so the BTB stays untouched
    foreach (vt[k]) begin
      @(negedge clk);
      ex_set(vt[k].v, vt[k].pc, vt[k].typ, vt[k].e, vt[k].gt, vt[k].bt, vt[k].o1, vt[k].ept, vt[k].eptt);
      #1;
      chk($sformatf("vec%0d_branchPC", k), branchPC, vt[k].x_bpc);
      chk($sformatf("vec%0d_taken", k), 32'(isBranchTaken), 32'(vt[k].x_tk));
      chk($sformatf("vec%0d_mispredict", k), 32'(mispredict), 32'(vt[k].x_mis));
      chk($sformatf("vec%0d_redirect", k), redirect_pc, vt[k].x_redir);
    end
    ex_valid = 0;
    tick();
    rst_n = 1;

    // allocate on taken miss
    fetch_pc = 32'h40;
    ex_set(1, 32'h40, 4'b0010, 1, 0, 32'h100, 0, 0, 0);
    #1;
    chk("s1_pred_taken", 32'(pred_taken), 0);
    chk("s1_pred_target", pred_target, 0);
    chk("s1_taken", 32'(isBranchTaken), 1);
    chk("s1_mispredict", 32'(mispredict), 1);
    chk("s1_redirect", redirect_pc, 32'h100);
    tick();
    ex_valid = 0; #1;
    chk("s1_next_pred_taken", 32'(pred_taken), 1);
    chk("s1_next_pred_target", pred_target, 32'h100);

    // not taken twice
    ex_set(1, 32'h40, 4'b0010, 0, 0, 32'h100, 0, 1, 32'h100);
    #1;
    chk("s2_mispredict", 32'(mispredict), 1);
    chk("s2_redirect", redirect_pc, 32'h44);
    tick();
    ex_valid = 0; #1;
    chk("s2_pred_taken", 32'(pred_taken), 0);
    ex_set(1, 32'h40, 4'b0010, 0, 0, 32'h100, 0, 0, 0);
    #1;
    chk("s2b_mispredict", 32'(mispredict), 0);
    tick();

    // return: target retrained to op1 (ctr 00 -> 01 -> 10)
    ex_set(1, 32'h40, 4'b1100, 0, 0, 32'h300, 32'h2000, 1, 32'h300);
    #1;
    chk("s3_branchPC", branchPC, 32'h2000);
    chk("s3_mispredict", 32'(mispredict), 1);
    chk("s3_redirect", redirect_pc, 32'h2000);
    tick();
    ex_pred_taken = 0;
    tick();
    ex_valid = 0; #1;
    chk("s3_pred_taken", 32'(pred_taken), 1);
    chk("s3_pred_target", pred_target, 32'h2000);

    // aliasing
    fetch_pc = 32'h440; #1;
    chk("s4_alias_miss", 32'(pred_taken), 0);
    ex_set(1, 32'h40, 4'b0000, 0, 0, 32'h300, 0, 1, 32'h2000);
    #1;
    chk("s4_taken", 32'(isBranchTaken), 0);
    chk("s4_mispredict", 32'(mispredict), 1);
    chk("s4_redirect", redirect_pc, 32'h44);
    tick();
    ex_valid = 0; fetch_pc = 32'h40; #1;
    chk("s4_invalidated", 32'(pred_taken), 0);

    // same-cycle update and lookup
    fetch_pc = 32'h80;
    ex_set(1, 32'h80, 4'b0100, 0, 0, 32'h500, 0, 0, 0);
    #1;
    chk("s5_old_pred", 32'(pred_taken), 0);
    tick();
    ex_valid = 0; #1;
    chk("s5_new_pred", 32'(pred_taken), 1);
    chk("s5_new_target", pred_target, 32'h500);

    // reset beats a same-cycle allocate
    rst_n = 0;
    ex_set(1, 32'hC0, 4'b0100, 0, 0, 32'h600, 0, 0, 0);
    tick();
    rst_n = 1; ex_valid = 0; fetch_pc = 32'hC0; #1;
    chk("s6_no_alloc", 32'(pred_taken), 0);
    fetch_pc = 32'h80; #1;
    chk("s6_cleared", 32'(pred_taken), 0);
    chk("s6_target_zero", pred_target, 0);

    // perf counters: 5 branches, 2 mispredicts
    ex_set(1, 32'h200, 4'b0100, 0, 0, 32'h300, 0, 0, 0);        tick();
    ex_set(1, 32'h200, 4'b0100, 0, 0, 32'h300, 0, 1, 32'h300);  tick();
    ex_set(1, 32'h204, 4'b0010, 0, 0, 32'h300, 0, 0, 0);        tick();
    ex_set(1, 32'h208, 4'b0001, 0, 0, 32'h300, 0, 0, 0);        tick();
    ex_set(1, 32'h20C, 4'b0000, 0, 0, 32'h300, 0, 0, 0);        tick();
    ex_set(1, 32'h210, 4'b0100, 0, 0, 32'h300, 0, 1, 32'h999); tick();
    ex_valid = 0; #1;
`ifdef BRANCH_PERF_EN
    chk("perf_branch_count", 32'(branch_count), 5);
    chk("perf_mispredict_count", 32'(mispredict_count), 2);
`else
    chk("perf_branch_count_off", 32'(branch_count), 0);
    chk("perf_mispredict_count_off", 32'(mispredict_count), 0);
`endif
    for (int k = 0; k < 20; k++) begin
      ex_set(1, 32'h300, 4'b0010, k[0], 0, 32'h400, 0, 0, 0);
      tick();
    end
    ex_valid = 0; #1;
`ifdef BRANCH_PERF_EN
    chk("perf_branch_sat", 32'(branch_count), 15);
`else
    chk("perf_branch_sat_off", 32'(branch_count), 0);
`endif

    // randomized against the model
    for (int n = 0; n < 400; n++) begin
      int t;
      rst_n    = ($urandom_range(0, 39) != 0);
      fetch_pc = rnd_pc();
      t = $urandom_range(0, 5);
      ex_set($urandom_range(0, 3) != 0, rnd_pc(),
             (t == 1) ? 4'b1100 : (t == 2) ? 4'b0100 : (t == 3) ? 4'b0010 :
             (t == 4) ? 4'b0001 : (t == 5) ? 4'b1000 : 4'b0000,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom_range(1, 8)) << 4, 32'($urandom_range(1, 8)) << 8,
             1'($urandom_range(0, 1)), 32'($urandom_range(1, 8)) << 4);
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken  = m_ptk(ex_pc);
        ex_pred_target = m_ptgt(ex_pc);
      end
      #1;
      chk("rnd_pred_taken", 32'(pred_taken), 32'(m_ptk(fetch_pc)));
      chk("rnd_pred_target", pred_target, m_ptgt(fetch_pc));
      chk("rnd_branchPC", branchPC, e_bpc());
      chk("rnd_taken", 32'(isBranchTaken), 32'(e_tk()));
      chk("rnd_mispredict", 32'(mispredict), 32'(e_mis()));
      chk("rnd_redirect", redirect_pc, e_redir());
`ifdef BRANCH_PERF_EN
      chk("rnd_branch_count", 32'(branch_count), 32'(m_bcnt));
      chk("rnd_mispredict_count", 32'(mispredict_count), 32'(m_mcnt));
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Next-generation branch unit for the pipelined SimpleRISC core.
- Resolves branches in EX: branchPC is op1 on ret, otherwise branchTarget; taken = UBranch | (Beq & E) | (Bgt & GT).
- Adds a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, used for fetch-stage prediction.
- Detects mispredictions in EX and supplies the redirect PC to fetch and the flush request to the pipeline.

Parameters:
- ENTRIES, 16, number of BTB entries; power of 2, ≥2.
- IDX_W, log2(ENTRIES), index width; derived, not overridable.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- fetch_pc  in  32  PC being fetched (word aligned)
- pred_taken  out  1  fetch prediction: taken
- pred_target  out  32  fetch predicted target (0 when pred_taken=0)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  32  PC of the EX instruction
- ex_pred_taken  in  1  pred_taken piped along with the instruction
- ex_pred_target  in  32  pred_target piped along with the instruction
- branchTarget  in  32  immediate branch target
- op1  in  32  return address operand
- isRet, isUBranch, isBeq, isBgt  in  1 each  decoded branch type
- flagsE, flagsGT  in  1 each  flags register
- branchPC  out  32  resolved target
- isBranchTaken  out  1  resolved taken
- mispredict  out  1  flush/redirect request
- redirect_pc  out  32  fetch restart PC
- branch_count  out  CNT_W  resolved branches (feature only)
- mispredict_count  out  CNT_W  mispredicts (feature only)

Behaviour:
- Indexing:
  - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup (combinational, read-before-write):
  - hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[1]; pred_target = pred_taken ? target : 0.
  - A same-cycle update to the same index is not visible until the next cycle.
- Resolution (combinational): branchPC and isBranchTaken are as in the Overview, independent of ex_valid.
- Branch definition: is_br = isRet | isUBranch | isBeq | isBgt.
- mispredict = ex_valid & ((ex_pred_taken != isBranchTaken) | (isBranchTaken & ex_pred_target != branchPC)).
- redirect_pc = isBranchTaken ? branchPC : ex_pc + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0). It is meaningful only when mispredict=1.
- BTB update, at the clock edge, when ex_valid=1, indexed by ex_pc:
  - is_br, hit, taken: ctr = sat_inc(ctr); target = branchPC.
  - is_br, hit, not taken: ctr = sat_dec(ctr); target is unchanged.
  - is_br, miss, taken: allocate with valid=1, new tag, target=branchPC, ctr=2'b10. Overwrites any existing entry.
  - is_br, miss, not taken: no change.
  - !is_br with hit (alias): valid = 0.
  - ex_valid = 0: no change.
- Counter saturation: ctr saturates at 2'b11 and 2'b00.
- Reset (rst_n=0 at posedge):
  - All valid bits = 0 and all ctr = 2'b01; target and tag are don't-care.
  - pred_taken = 0 and pred_target = 0 from the next cycle.
  - Counters clear to 0.
  - Reset overrides any same-cycle update.
  - Resolution outputs stay combinational, even during reset.
- Reset mid-stream: no stale prediction survives. The pipeline must deassert ex_valid while rst_n=0.
- No handshake. One update per cycle. Lookup latency 0 cycles; update visible 1 cycle later.

Optional Feature:
- BRANCH_PERF_EN defined:
  - branch_count increments on ex_valid & is_br.
  - mispredict_count increments on mispredict.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset then fetch_pc=0x40 → pred_taken=0, pred_target=0. Resolve a Beq at 0x40 with E=1, branchTarget=0x100 and ex_pred_taken=0 → isBranchTaken=1, mispredict=1, redirect_pc=0x100. Next cycle fetch 0x40 → pred_taken=1, pred_target=0x100.
- Same entry (ctr=10), Beq not taken twice → first: mispredict=1, redirect_pc=0x44, ctr=01. Next fetch of 0x40 → pred_taken=0.
- isRet, op1=0x2000, branchTarget=0x300, ex_pred_taken=1, ex_pred_target=0x300 → branchPC=0x2000, mispredict=1, redirect_pc=0x2000. Entry target becomes 0x2000.
- Aliasing, ENTRIES=16: taken branch at 0x40 allocated; fetch 0x440 → miss (tag differs). Non-branch at 0x40 with ex_pred_taken=1 → mispredict=1, redirect_pc=0x44, entry invalidated.
- Same-cycle update and lookup of idx of 0x80 → pred reflects the old entry this cycle and the new entry next cycle. rst_n=0 in the same cycle as an allocate → the entry stays invalid.
- BRANCH_PERF_EN defined: 5 branches with 2 mispredicts → branch_count=5, mispredict_count=2. CNT_W=4 with 20 branches → branch_count saturates at 15.
